// File: rtl/tdm_mux_tx_pkg.sv
// rtl/tdm_mux_tx_pkg.sv - parameters and helpers for the TDM transmitter
`include "tdm_defs.vh"

package tdm_mux_tx_pkg;

  localparam int TDM_CHANNELS_P = `TDM_CHANNELS;
  localparam int TDM_WIDTH_P    = `TDM_WIDTH;
  localparam int TDM_SLOT_W_P   = `TDM_SLOT_W;
  localparam int TDM_SYNC_SLOT  = `TDM_SYNC_SLOT;

  function automatic logic is_sync_slot(input int unsigned slot);
    return slot == TDM_SYNC_SLOT;
  endfunction

endpackage

// File: rtl/tdm_defs.vh
// rtl/tdm_defs.vh - TDM link constants shared by transmitter and receiver
`ifndef TDM_DEFS_VH
`define TDM_DEFS_VH
`define TDM_CHANNELS  4
`define TDM_WIDTH     8
`define TDM_SLOT_W    2
// Frame sync is flagged on the line word carrying this slot index.
`define TDM_SYNC_SLOT 0
`endif

// File: rtl/tdm_slot_buffer.sv
// rtl/tdm_slot_buffer.sv - one-entry holding register for a single TDM channel
module tdm_slot_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic             full,
  output logic [WIDTH-1:0] rdata
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // The owner only writes when empty and only reads when full, so wr and rd never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (rd) begin
      full_d = 1'b0;
    end
    if (wr) begin
      full_d = 1'b1;
      data_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full  = full_q;
  assign rdata = data_q;

endmodule

// File: rtl/tdm_mux_tx.sv
// rtl/tdm_mux_tx.sv - merges CHANNELS valid/ready streams onto one slotted TDM line
import tdm_mux_tx_pkg::*;

module tdm_mux_tx #(
  parameter int WIDTH    = TDM_WIDTH_P,
  parameter int CHANNELS = TDM_CHANNELS_P,
  parameter int SLOT_W   = TDM_SLOT_W_P
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [CHANNELS-1:0]       ch_valid,
  output logic [CHANNELS-1:0]       ch_ready,
  output logic [WIDTH-1:0]          line_data,
  output logic                      line_valid,
  output logic                      line_sync,
  output logic [SLOT_W-1:0]         line_slot
);

  logic [SLOT_W-1:0] cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              sync_q, sync_d;

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] wr;
  logic [CHANNELS-1:0] rd;
  logic [WIDTH-1:0]    rdata [CHANNELS];

  assign ch_ready = ~full;
  assign wr       = ch_valid & ch_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    // Drain only a full buffer so the read strobe can never overlap an accept.
    assign rd[g] = en && (cnt_q == SLOT_W'(g)) && full[g];

    tdm_slot_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[g]),
      .wdata (ch_data[g*WIDTH +: WIDTH]),
      .rd    (rd[g]),
      .full  (full[g]),
      .rdata (rdata[g])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    data_d  = '0;
    if (en) begin
      cnt_d   = cnt_q + 1'b1;
      slot_d  = cnt_q;
      sync_d  = is_sync_slot(32'(cnt_q));
      valid_d = full[cnt_q];
      data_d  = full[cnt_q] ? rdata[cnt_q] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
    end
  end

  assign line_data  = data_q;
  assign line_valid = valid_q;
  assign line_sync  = sync_q;
  assign line_slot  = slot_q;

endmodule

// File: tb/tb_tdm_mux_tx.sv
// tb/tb_tdm_mux_tx.sv - directed and random stimulus against a frame-level reference model
module tb_tdm_mux_tx;

  localparam int CH = 4;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [CH*W-1:0]   ch_data = '0;
  logic [CH-1:0]     ch_valid = '0;
  logic [CH-1:0]     ch_ready;
  logic [W-1:0]      line_data;
  logic              line_valid;
  logic              line_sync;
  logic [1:0]        line_slot;

  tdm_mux_tx #(.WIDTH(W), .CHANNELS(CH), .SLOT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .line_data  (line_data),
    .line_valid (line_valid),
    .line_sync  (line_sync),
    .line_slot  (line_slot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending word per channel plus the frame position of the next slot.
  int m_pending [CH];
  int m_word    [CH];
  int m_pos;
  int e_slot, e_sync, e_valid, e_data;
  int m_emitted, dut_emitted;
  logic [CH-1:0] last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_pending[k] = 0;
      m_word[k]    = 0;
    end
    m_pos  = 0;
    e_slot = 0; e_sync = 0; e_valid = 0; e_data = 0;
  endtask

  task automatic step();
    logic [CH-1:0] acc;
    logic [CH-1:0] exp_ready;
    acc = '0;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < CH; k++) acc[k] = ch_valid[k] && (m_pending[k] == 0);
      if (en) begin
        e_slot  = m_pos;
        e_sync  = (m_pos == 0);
        e_valid = m_pending[m_pos];
        e_data  = m_pending[m_pos] ? m_word[m_pos] : 0;
        m_emitted += e_valid;
        m_pending[m_pos] = 0;
        m_pos = (m_pos + 1) % CH;
      end else begin
        e_sync = 0; e_valid = 0; e_data = 0;
      end
      for (int k = 0; k < CH; k++) begin
        if (acc[k]) begin
          m_pending[k] = 1;
          m_word[k]    = int'(ch_data[k*W +: W]);
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) exp_ready[k] = (m_pending[k] == 0);
    if (line_valid === 1'b1) dut_emitted++;
    check("line_slot",  32'(line_slot),  32'(e_slot));
    check("line_sync",  32'(line_sync),  32'(e_sync));
    check("line_valid", 32'(line_valid), 32'(e_valid));
    check("line_data",  32'(line_data),  32'(e_data));
    check("ch_ready",   32'(ch_ready),   32'(exp_ready));
  endtask

  initial begin
    logic [W-1:0] bp_words [2];
    int idx;
    int n;
    model_reset();
    m_emitted = 0;
    dut_emitted = 0;

    // Reset held two cycles while every channel offers a word.
    rst = 1'b1; ch_valid = 4'b1111; ch_data = 32'hDEADBEEF;
    step(); step();
    rst = 1'b0; ch_valid = '0;
    check("reset_ready", 32'(ch_ready), 32'hF);

    // Full frame: load all channels with rotation paused at slot 0, then run one frame.
    en = 1'b0; ch_valid = 4'b1111; ch_data = 32'h44332211;
    step();
    ch_valid = '0; en = 1'b1;
    for (int i = 0; i < CH; i++) begin
      step();
      check("frame_data", 32'(line_data), 32'(8'h11 * (i + 1)));
    end

    // Sparse: only channel 2 carries a word.
    ch_valid = 4'b0100; ch_data = 32'h00A50000;
    step();
    ch_valid = '0;
    for (int i = 0; i < 2 * CH; i++) step();

    // Backpressure: channel 1 offers two words back-to-back, holding valid until accepted.
    bp_words[0] = 8'h01; bp_words[1] = 8'h02; idx = 0;
    for (int i = 0; i < 3 * CH && idx < 3; i++) begin
      ch_valid = (idx < 2) ? 4'b0010 : 4'b0000;
      ch_data  = (idx < 2) ? {16'h0, bp_words[idx], 8'h0} : '0;
      step();
      if (last_acc[1]) idx++;
    end
    ch_valid = '0;
    check("bp_both_accepted", 32'(idx), 32'd2);
    for (int i = 0; i < CH; i++) step();

    // Enable pause at slot 1 with channel 2 full.
    n = 0;
    while (m_pos != 1 && n < 2 * CH) begin step(); n++; end
    check("pause_align", 32'(m_pos), 32'd1);
    en = 1'b0; ch_valid = 4'b0100; ch_data = {8'h0, 8'($urandom), 16'h0};
    step();
    ch_valid = '0; en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    step();
    check("resume_ch2_valid", 32'(line_valid), 32'd1);
    for (int i = 0; i < CH; i++) step();

    // Mid-run reset with channels 0 and 3 holding words.
    en = 1'b0; ch_valid = 4'b1001; ch_data = 32'h7700_0066;
    step();
    ch_valid = '0; rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < CH + 1; i++) step();

    // Random traffic with occasional pauses and resets.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 7) != 0);
      ch_valid = 4'($urandom);
      ch_data  = $urandom;
      step();
    end
    rst = 1'b0; ch_valid = '0; en = 1'b1;
    for (int i = 0; i < CH; i++) step();

    check("emitted_total", 32'(dut_emitted), 32'(m_emitted));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
